// File: rtl/ysyx_041461_if_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ysyx_041461_if_ctrl_pkg;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_3000_0000;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_OUT   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } if_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_WB   = 2'd1,
        REDIR_ID   = 2'd2
    } redir_src_e;

    // Only word-aligned PCs may be sent to instruction memory.
    function automatic logic pc_aligned(input logic [63:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_041461_if_ctrl_chk.sv
// Protocol checker: responses may only arrive while a request is outstanding.
module ysyx_041461_if_ctrl_chk
    import ysyx_041461_if_ctrl_pkg::*;
(
    input logic      clk,
    input logic      rst_n,
    input logic      mem_resp_valid,
    input if_state_e state
);

    resp_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        mem_resp_valid |-> (state == ST_WAIT || state == ST_DRAIN))
        else $error("if_ctrl: mem_resp_valid with no outstanding request");

endmodule

// File: rtl/ysyx_041461_if_ctrl_redir_arb.sv
// PC redirect arbiter: WB (trap/mret) has priority over ID (branch/jump).
module ysyx_041461_if_redir_arb
    import ysyx_041461_if_ctrl_pkg::*;
(
    input  logic        redir_wb_valid,
    input  logic [63:0] redir_wb_pc,
    input  logic        redir_id_valid,
    input  logic [63:0] redir_id_pc,
    output logic        redir_take,
    output logic [63:0] redir_pc
);

    redir_src_e src_s;

    // Fixed-priority select of the redirect source and its target.
    always_comb begin
        src_s    = REDIR_NONE;
        redir_pc = 64'h0;
        if (redir_wb_valid) begin
            src_s    = REDIR_WB;
            redir_pc = redir_wb_pc;
        end else if (redir_id_valid) begin
            src_s    = REDIR_ID;
            redir_pc = redir_id_pc;
        end else begin
            src_s    = REDIR_NONE;
            redir_pc = 64'h0;
        end
    end

    assign redir_take = (src_s != REDIR_NONE);

endmodule

// File: rtl/ysyx_041461_if_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues single-outstanding
// reads, drops stale responses after redirects and hands words to ID.
module ysyx_041461_if_ctrl
    import ysyx_041461_if_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir_wb_valid,
    input  logic [63:0] redir_wb_pc,
    input  logic        redir_id_valid,
    input  logic [63:0] redir_id_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_fault,
    input  logic        id_ready,
    output logic [63:0] pc_o
);

    logic        redir_take_s;
    logic [63:0] redir_pc_s;

    if_state_e   state_r;
    logic [63:0] pc_r;
    logic        req_valid_r;
    logic        if_valid_r;
    logic [63:0] if_pc_r;
    logic [31:0] if_inst_r;
    logic        if_fault_r;

    ysyx_041461_if_redir_arb u_arb (
        .redir_wb_valid (redir_wb_valid),
        .redir_wb_pc    (redir_wb_pc),
        .redir_id_valid (redir_id_valid),
        .redir_id_pc    (redir_id_pc),
        .redir_take     (redir_take_s),
        .redir_pc       (redir_pc_s)
    );

    ysyx_041461_if_ctrl_chk u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_resp_valid (mem_resp_valid),
        .state          (state_r)
    );

    // Fetch FSM; req_valid_r is precomputed from the next state so the
    // request strobe is a flop and stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_REQ;
            pc_r        <= RESET_PC;
            req_valid_r <= 1'b0;
            if_valid_r  <= 1'b0;
            if_pc_r     <= 64'h0;
            if_inst_r   <= 32'h0;
            if_fault_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (redir_take_s) begin
                        pc_r <= redir_pc_s;
                        if (req_valid_r && mem_req_ready) begin
                            state_r     <= ST_DRAIN;
                            req_valid_r <= 1'b0;
                        end else begin
                            req_valid_r <= pc_aligned(redir_pc_s);
                        end
                    end else if (!pc_aligned(pc_r)) begin
                        state_r     <= ST_OUT;
                        req_valid_r <= 1'b0;
                        if_valid_r  <= 1'b1;
                        if_pc_r     <= pc_r;
                        if_inst_r   <= 32'h0;
                        if_fault_r  <= 1'b1;
                    end else if (req_valid_r && mem_req_ready) begin
                        state_r     <= ST_WAIT;
                        req_valid_r <= 1'b0;
                    end else begin
                        req_valid_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid && redir_take_s) begin
                        pc_r        <= redir_pc_s;
                        state_r     <= ST_REQ;
                        req_valid_r <= pc_aligned(redir_pc_s);
                    end else if (mem_resp_valid) begin
                        state_r    <= ST_OUT;
                        if_valid_r <= 1'b1;
                        if_pc_r    <= pc_r;
                        if_inst_r  <= mem_resp_err ? 32'h0 : mem_resp_data;
                        if_fault_r <= mem_resp_err;
                    end else if (redir_take_s) begin
                        pc_r    <= redir_pc_s;
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (redir_take_s) begin
                        if_valid_r  <= 1'b0;
                        pc_r        <= redir_pc_s;
                        state_r     <= ST_REQ;
                        req_valid_r <= pc_aligned(redir_pc_s);
                    end else if (id_ready && if_fault_r) begin
                        if_valid_r <= 1'b0;
                        state_r    <= ST_HALT;
                    end else if (id_ready) begin
                        if_valid_r  <= 1'b0;
                        pc_r        <= pc_r + 64'd4;
                        state_r     <= ST_REQ;
                        req_valid_r <= pc_aligned(pc_r + 64'd4);
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                ST_DRAIN: begin
                    if (redir_take_s) begin
                        pc_r <= redir_pc_s;
                        if (mem_resp_valid) begin
                            state_r     <= ST_REQ;
                            req_valid_r <= pc_aligned(redir_pc_s);
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end else if (mem_resp_valid) begin
                        state_r     <= ST_REQ;
                        req_valid_r <= pc_aligned(pc_r);
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    if (redir_take_s) begin
                        pc_r        <= redir_pc_s;
                        state_r     <= ST_REQ;
                        req_valid_r <= pc_aligned(redir_pc_s);
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                default: begin
                    state_r     <= ST_REQ;
                    req_valid_r <= 1'b0;
                    if_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = pc_r;
    assign pc_o          = pc_r;
    assign if_valid      = if_valid_r;
    assign if_pc         = if_pc_r;
    assign if_inst       = if_inst_r;
    assign if_fault      = if_fault_r;

endmodule

// File: doc/ysyx_041461_if_ctrl.md
Name: ysyx_041461_IF_ctrl

Overview:
Instruction-fetch controller that owns the fetch PC and sequences instruction reads over a single-outstanding valid/ready memory port. It arbitrates PC redirects from WB (trap/mret, already resolved to a target) and ID (branch/jump), and drops stale responses after a redirect. It also presents fetched instructions to ID through a valid/ready handshake. It sits between the PC/next-PC logic and the instruction memory interface.

Parameters:
RESET_PC, 64'h0000_0000_3000_0000, fetch PC loaded on reset

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
redir_wb_valid  input  1  WB redirect request (trap entry / mret)
redir_wb_pc  input  64  WB redirect target
redir_id_valid  input  1  ID redirect request (taken branch / jump)
redir_id_pc  input  64  ID redirect target
mem_req_valid  output  1  fetch request valid
mem_req_addr  output  64  fetch address (= pc_o)
mem_req_ready  input  1  memory accepts request
mem_resp_valid  input  1  fetch response valid (always accepted)
mem_resp_data  input  32  instruction word
mem_resp_err  input  1  access fault on this response
if_valid  output  1  instruction valid to ID
if_pc  output  64  PC of presented instruction
if_inst  output  32  instruction word
if_fault  output  1  instruction carries fetch fault
id_ready  input  1  ID accepts instruction
pc_o  output  64  current fetch PC

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC, state=REQ, mem_req_valid=0 while in reset, if_valid=0, if_pc=0, if_inst=0, if_fault=0.
- Redirect arbitration: WB beats ID when both are asserted in the same cycle. A redirect is "taken" only if at least one of the valids is high. It always loads pc_o with the winning target on the next edge.
- States:
  - REQ: mem_req_valid=1, mem_req_addr=pc_o.
    - pc_o[1:0]!=0: no request issued; go to OUT with if_fault=1, if_inst=0, if_pc=pc_o.
    - Redirect without ready: pc_o updates, stay in REQ. The request address may change because it has not been accepted.
    - ready && redirect: the stale request was accepted; go to DRAIN with the new pc_o.
    - ready only: go to WAIT.
  - WAIT: mem_req_valid=0.
    - resp && redirect: drop the response, load pc_o, go to REQ.
    - resp only: register if_pc=pc_o, if_inst=data (0 if err), if_fault=err, then go to OUT.
    - redirect only: load pc_o, go to DRAIN.
  - OUT: if_valid=1; if_pc, if_inst and if_fault are held stable until the handshake.
    - Redirect: if_valid drops next cycle (instruction discarded even if id_ready was high), load pc_o, go to REQ.
    - if_valid && id_ready, fault=0: pc_o<=pc_o+4 (mod 2^64), go to REQ.
    - if_valid && id_ready, fault=1: pc_o unchanged, go to HALT.
  - DRAIN: mem_req_valid=0.
    - The next mem_resp_valid is discarded, then go to REQ.
    - Redirect in DRAIN updates pc_o and stays in DRAIN. If it coincides with the response, the response is discarded and the state goes to REQ with the new pc_o.
  - HALT: no requests, if_valid=0. Leave only on a redirect (normally WB trap): load pc_o, go to REQ.
- Latency: request accept to earliest if_valid is 2 cycles (response cycle + register). Handshake to next mem_req_valid is 1 cycle.
- At most one request outstanding. mem_resp_valid in REQ, OUT or HALT is a protocol error; it is ignored and flagged by an assertion.
- Reset mid-transaction: all state is lost immediately. The bench must not return a response for a pre-reset request.

Decomposition:
- Shared package / defines header: state encodings (REQ, WAIT, OUT, DRAIN, HALT; 3-bit), RESET_PC default, redirect-source encoding.
- One natural sub-module: ysyx_041461_IF_redir_arb. It is combinational WB>ID priority select and produces redir_take and redir_pc. Everything else stays in the FSM module.

Test Plan:
- Reset release, mem_req_ready=1, resp one cycle later with data 0x00000013 -> req addr 0x30000000; if_valid with if_pc=0x30000000, if_inst=0x13. After id_ready, next req addr is 0x30000004.
- Both redirects in the same cycle while in WAIT (WB=0x80000000, ID=0x30000100), then stale resp -> stale resp dropped, no if_valid for it; next req addr is 0x80000000.
- Hold id_ready=0 for 5 cycles in OUT -> if_valid, if_pc and if_inst are stable for all 5 cycles; pc_o advances by 4 only on the handshake cycle.
- Resp with mem_resp_err=1 at 0x30000008 -> if_fault=1, if_inst=0. After handshake, no requests are issued (HALT). A WB redirect to 0x30001000 resumes fetch at that address.
- ID redirect to 0x30000002 -> no memory request issued; if_valid with if_fault=1, if_pc=0x30000002.
- Assert rst_n=0 mid-WAIT -> outputs return immediately to reset values, pc_o=0x30000000; the first request after release is at RESET_PC.
